riscv_data_mem_ctrl: RTL

- Parametrised data-memory block for the single-cycle and upcoming multi-cycle RISC-V cores.
- Replaces the bench-level word-only memory model with synthesizable RTL.
- Supports byte, halfword and word loads and stores with sign/zero extension.
- Supports configurable wait states through a req/ready handshake.
- Flags misaligned, out-of-range and illegal-size accesses instead of silently corrupting memory.

---
 rtl/riscv_data_mem_ctrl_if.sv | 29 ++
 rtl/riscv_data_mem_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/riscv_data_mem_ctrl_if.sv
// Request/response bundle for riscv_data_mem_ctrl.
//   master (requester): drives req, we, funct3, addr, wdata; observes ready, rdata, err, busy.
//   slave  (memory)   : the mirror image.
// req/we/funct3/addr/wdata are sampled only when the controller accepts a request.
// ready is a one-cycle completion pulse; rdata/err are valid while it is high.
// busy is high from acceptance until the end of the ready cycle.
interface riscv_data_mem_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();
  logic                  req;
  logic                  we;
  logic [2:0]            funct3;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic                  ready;
  logic [31:0]           rdata;
  logic                  err;
  logic                  busy;

  modport master (
    output req, we, funct3, addr, wdata,
    input  ready, rdata, err, busy
  );

  modport slave (
    input  req, we, funct3, addr, wdata,
    output ready, rdata, err, busy
  );
endinterface

// File: rtl/riscv_data_mem_ctrl.sv
// Data memory for the RISC-V cores: byte/half/word loads and stores with
// sign/zero extension, a programmable number of wait states, and fault
// reporting for illegal sizes, out-of-range and misaligned addresses.
// Ports:
//   clk   - clock, all state changes on the rising edge
//   reset - synchronous, active-low; memory contents are kept
//   bus   - riscv_data_mem_ctrl_if slave modport (req/we/funct3/addr/wdata in,
//           ready/rdata/err/busy out)
module riscv_data_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  riscv_data_mem_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_word;
  logic [31:0]      wr_word;
  logic [31:0]      ld_val;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic             illegal, out_of_range, misaligned, fault;
  logic             mem_we;

  // Decode of the captured transaction; only consumed on the final WAIT cycle.
  always_comb begin
    idx          = addr_q[IDX_W+1:2];
    rd_word      = mem[idx];
    // Range check at full address width so high addresses cannot alias low words.
    out_of_range = (64'(addr_q[ADDR_WIDTH-1:2]) >= 64'(DEPTH_WORDS));
    if (we_q) illegal = f3_q[2] || (f3_q[1:0] == 2'b11);
    else      illegal = (f3_q[1:0] == 2'b11) || (f3_q[2:1] == 2'b11);
    misaligned = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                 ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    fault      = illegal || out_of_range || misaligned;

    ld_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (f3_q)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_val = rd_word;
      3'b100:  ld_val = {24'h0, ld_byte};
      3'b101:  ld_val = {16'h0, ld_half};
      default: ld_val = '0;
    endcase

    // Read-modify-write merge keeps the untouched byte lanes.
    wr_word = rd_word;
    case (f3_q[1:0])
      2'b00:   wr_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   wr_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: wr_word = wdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          f3_d    = bus.funct3;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          cnt_d   = 4'(WAIT_STATES);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          err_d   = fault;
          rdata_d = (fault || we_q) ? '0 : ld_val;
          mem_we  = we_q && !fault;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Reset in the commit cycle aborts the store.
  always_ff @(posedge clk) begin
    if (reset && mem_we) mem[idx] <= wr_word;
  end

  assign bus.ready = (state_q == S_RESP);
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;

endmodule
